// File: rtl/mxregs_ctx_pkg.sv
// Shared types and constants for the context register file.
package mxregs_ctx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ctx_state_e;

  // Combined-load codes sit just past the single-register range:
  // load_addr == DEPTH + LD_OFS_* selects a register pair.
  localparam int LD_OFS_FLAGS_A = 0;
  localparam int LD_OFS_FLAGS_D = 1;

  // Default register map.
  localparam int IDX_A     = 0;
  localparam int IDX_X     = 1;
  localparam int IDX_Y     = 2;
  localparam int IDX_D     = 3;
  localparam int IDX_FLAGS = 7;
  localparam int IDX_SA    = 8;
  localparam int IDX_SB    = 9;
  localparam int IDX_SC    = 10;
  localparam int IDX_SD    = 11;

endpackage

// File: rtl/mxregs_ctx_if.sv
// Save/restore streaming bus. The slave side is the register file.
interface mxregs_ctx_if #(
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_LENGTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );

  modport slave (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );
endinterface

// File: rtl/mxregs_ctx_decoder.sv
// Load selector decode: one register, a FLAGS pair, or nothing.
module mxregs_ctx_decoder
  import mxregs_ctx_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CTX_BASE  = IDX_A,
  parameter int FLAGS_IDX = IDX_FLAGS
) (
  input  logic [7:0]       i_load_addr,
  input  logic             i_load_en,
  output logic [DEPTH-1:0] o_sel
);

  logic [31:0] w_addr;
  assign w_addr = {24'd0, i_load_addr};

  // One-hot for direct addresses, two-hot for the combined codes.
  always_comb begin
    o_sel = '0;
    if (i_load_en) begin
      for (int i = 0; i < DEPTH; i++)
        if (w_addr == 32'(i)) o_sel[i] = 1'b1;
      if (w_addr == 32'(DEPTH + LD_OFS_FLAGS_A)) begin
        o_sel[FLAGS_IDX] = 1'b1;
        o_sel[CTX_BASE]  = 1'b1;
      end
      if (w_addr == 32'(DEPTH + LD_OFS_FLAGS_D)) begin
        o_sel[FLAGS_IDX]                = 1'b1;
        o_sel[CTX_BASE + IDX_D - IDX_A] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mxregs_ctx.sv
// Register file with primary/shadow context swap and a streaming
// save (A..D out) / restore (D..A in) engine.
module mxregs_ctx
  import mxregs_ctx_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16,
  parameter int CTX_BASE    = IDX_A,
  parameter int CTX_COUNT   = 4,
  parameter int SHD_BASE    = IDX_SA,
  parameter int FLAGS_IDX   = IDX_FLAGS
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  output logic [DEPTH-1:0][WORD_LENGTH-1:0] o_reg_line,
  input  logic [DEPTH-1:0][WORD_LENGTH-1:0] i_data_line,
  input  logic [7:0]                        i_load_addr,
  input  logic                              i_load_en,
  input  logic                              i_swap_req,
  input  logic                              i_save_start,
  input  logic                              i_restore_start,
  output logic                              o_busy,
  output logic                              o_done,
  mxregs_ctx_if.slave                       s_if
);

  localparam int IDXW = (CTX_COUNT > 1) ? $clog2(CTX_COUNT) : 1;

  ctx_state_e                        r_state;
  logic [IDXW-1:0]                   r_idx;
  logic                              r_done;
  logic [DEPTH-1:0][WORD_LENGTH-1:0] r_regs;

  logic [DEPTH-1:0] w_sel;
  logic             w_idle, w_swap, w_rest_wr, w_last_up, w_last_dn;

  mxregs_ctx_decoder #(
    .DEPTH(DEPTH), .CTX_BASE(CTX_BASE), .FLAGS_IDX(FLAGS_IDX)
  ) u_dec (
    .i_load_addr(i_load_addr),
    .i_load_en  (i_load_en),
    .o_sel      (w_sel)
  );

  assign w_idle    = (r_state == ST_IDLE);
  // A start request pre-empts a swap in the same cycle.
  assign w_swap    = w_idle & i_swap_req & ~i_save_start & ~i_restore_start;
  assign w_rest_wr = (r_state == ST_RESTORE) & s_if.in_valid;
  assign w_last_up = (r_idx == IDXW'(CTX_COUNT - 1));
  assign w_last_dn = (r_idx == '0);

  assign o_reg_line     = r_regs;
  assign o_busy         = ~w_idle;
  assign o_done         = r_done;
  assign s_if.out_valid = (r_state == ST_SAVE);
  assign s_if.in_ready  = (r_state == ST_RESTORE);

  // Live view of the register being saved; zero outside SAVE.
  always_comb begin
    s_if.out_data = '0;
    if (r_state == ST_SAVE)
      for (int i = 0; i < CTX_COUNT; i++)
        if (r_idx == IDXW'(i)) s_if.out_data = r_regs[CTX_BASE + i];
  end

  // Storage: loads, then swap, then restore write; later assignments win.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_sel[i]) r_regs[i] <= i_data_line[i];
      if (w_swap)
        for (int i = 0; i < CTX_COUNT; i++) begin
          r_regs[CTX_BASE + i] <= r_regs[SHD_BASE + i];
          r_regs[SHD_BASE + i] <= r_regs[CTX_BASE + i];
        end
      if (w_rest_wr)
        for (int i = 0; i < CTX_COUNT; i++)
          if (r_idx == IDXW'(i)) r_regs[CTX_BASE + i] <= s_if.in_data;
    end
  end

  // Stream FSM: SAVE walks idx upward, RESTORE walks it downward.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_save_start) begin
            r_state <= ST_SAVE;
            r_idx   <= '0;
          end else if (i_restore_start) begin
            r_state <= ST_RESTORE;
            r_idx   <= IDXW'(CTX_COUNT - 1);
          end
        end
        ST_SAVE: begin
          if (s_if.out_ready) begin
            if (w_last_up) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        ST_RESTORE: begin
          if (s_if.in_valid) begin
            if (w_last_dn) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx - IDXW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxregs_ctx.sv
// Bench for mxregs_ctx: directed vector table, a CTX_COUNT=1 sequence,
// then randomized traffic against a behavioural model.
module tb_mxregs_ctx;
  import mxregs_ctx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, load_en, swap, save0, rest0, save1, rest1;
  logic [7:0]       load_addr;
  logic [15:0][7:0] data_line, reg_line0, reg_line1;
  logic             busy0, done0, busy1, done1;

  mxregs_ctx_if #(.WORD_LENGTH(8)) if0();
  mxregs_ctx_if #(.WORD_LENGTH(8)) if1();

  mxregs_ctx dut (
    .i_clk(clk), .i_rst(rst), .o_reg_line(reg_line0), .i_data_line(data_line),
    .i_load_addr(load_addr), .i_load_en(load_en), .i_swap_req(swap),
    .i_save_start(save0), .i_restore_start(rest0),
    .o_busy(busy0), .o_done(done0), .s_if(if0.slave)
  );

  mxregs_ctx #(.CTX_COUNT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .o_reg_line(reg_line1), .i_data_line(data_line),
    .i_load_addr(load_addr), .i_load_en(load_en), .i_swap_req(1'b0),
    .i_save_start(save1), .i_restore_start(rest1),
    .o_busy(busy1), .o_done(done1), .s_if(if1.slave)
  );

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, en; logic [7:0] addr; logic [127:0] dl;
    logic swap, save, rest, ordy, ival; logic [7:0] idat;
    logic [127:0] e_regs; logic e_busy, e_done, e_ov, e_ir; logic [7:0] e_od;
  } vec_t;
  vec_t vq[$];

  localparam logic [127:0] G = 128'hF1E2D3C4_B5A69788_79685A4B_3C2D1E0F;

  function automatic logic [127:0] dw(input int idx, input logic [7:0] val);
    logic [15:0][7:0] d;
    d = G;
    d[idx] = val;
    return d;
  endfunction

  task automatic v(input logic r, en, input logic [7:0] addr, input logic [127:0] dl,
                   input logic sw, sv, rs, ordy, ival, input logic [7:0] idat,
                   input logic [127:0] er, input logic eb, ed, eov, eir, input logic [7:0] eod);
    vec_t t;
    t.rst = r; t.en = en; t.addr = addr; t.dl = dl; t.swap = sw; t.save = sv; t.rest = rs;
    t.ordy = ordy; t.ival = ival; t.idat = idat;
    t.e_regs = er; t.e_busy = eb; t.e_done = ed; t.e_ov = eov; t.e_ir = eir; t.e_od = eod;
    vq.push_back(t);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_r[16];
  int m_mode, m_k;   // 0 idle, 1 save, 2 restore; m_k = words transferred
  bit m_done;
  int save_ord[4] = '{IDX_A, IDX_X, IDX_Y, IDX_D};
  int rest_ord[4] = '{IDX_D, IDX_Y, IDX_X, IDX_A};
  int shd_ord[4]  = '{IDX_SA, IDX_SB, IDX_SC, IDX_SD};

  task automatic model_step();
    logic [7:0] nr[16];
    int a;
    if (rst) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_mode = 0; m_k = 0; m_done = 0;
      return;
    end
    nr = m_r;
    m_done = 0;
    a = int'(load_addr);
    if (load_en) begin
      if (a < 16) nr[a] = data_line[a];
      else if (a == 16) begin nr[IDX_FLAGS] = data_line[IDX_FLAGS]; nr[IDX_A] = data_line[IDX_A]; end
      else if (a == 17) begin nr[IDX_FLAGS] = data_line[IDX_FLAGS]; nr[IDX_D] = data_line[IDX_D]; end
    end
    if (m_mode == 0) begin
      if (save0) begin m_mode = 1; m_k = 0; end
      else if (rest0) begin m_mode = 2; m_k = 0; end
      else if (swap)
        for (int i = 0; i < 4; i++) begin
          nr[save_ord[i]] = m_r[shd_ord[i]];
          nr[shd_ord[i]]  = m_r[save_ord[i]];
        end
    end else if (m_mode == 1) begin
      if (if0.out_ready) begin
        m_k++;
        if (m_k == 4) begin m_mode = 0; m_done = 1; end
      end
    end else begin
      if (if0.in_valid) begin
        nr[rest_ord[m_k]] = if0.in_data;
        m_k++;
        if (m_k == 4) begin m_mode = 0; m_done = 1; end
      end
    end
    m_r = nr;
  endtask

  initial begin
    logic [15:0][7:0] er;
    rst = 1; load_en = 0; load_addr = 0; data_line = G; swap = 0;
    save0 = 0; rest0 = 0; save1 = 0; rest1 = 0;
    if0.out_ready = 0; if0.in_valid = 0; if0.in_data = 0;
    if1.out_ready = 0; if1.in_valid = 0; if1.in_data = 0;

    //  rst en addr  dl                swap save rest ordy ival idat  regs                                     busy done ov ir od
    v(1,0,8'h00,G,                     0,0,0,0,0,8'h00, 128'h0,                                   0,0,0,0,8'h00);
    v(0,1,8'h03,dw(3,8'h5A),           0,0,0,0,0,8'h00, 128'h00000000_00000000_00000000_5A000000, 0,0,0,0,8'h00);
    v(0,1,8'h10,128'hF1E2D3C4_B5A69788_81685A4B_3C2D1E22,
                                       0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A000022, 0,0,0,0,8'h00);
    v(0,1,8'h12,G,                     0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A000022, 0,0,0,0,8'h00);
    v(0,0,8'h03,dw(3,8'h77),           0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A000022, 0,0,0,0,8'h00);
    v(0,1,8'h00,dw(0,8'h01),           0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A000001, 0,0,0,0,8'h00);
    v(0,1,8'h01,dw(1,8'h02),           0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A000201, 0,0,0,0,8'h00);
    v(0,1,8'h02,dw(2,8'h03),           0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_5A030201, 0,0,0,0,8'h00);
    v(0,1,8'h03,dw(3,8'h04),           0,0,0,0,0,8'h00, 128'h00000000_00000000_81000000_04030201, 0,0,0,0,8'h00);
    v(0,1,8'h08,dw(8,8'h09),           0,0,0,0,0,8'h00, 128'h00000000_00000009_81000000_04030201, 0,0,0,0,8'h00);
    v(0,1,8'h09,dw(9,8'h08),           0,0,0,0,0,8'h00, 128'h00000000_00000809_81000000_04030201, 0,0,0,0,8'h00);
    v(0,1,8'h0A,dw(10,8'h07),          0,0,0,0,0,8'h00, 128'h00000000_00070809_81000000_04030201, 0,0,0,0,8'h00);
    v(0,1,8'h0B,dw(11,8'h06),          0,0,0,0,0,8'h00, 128'h00000000_06070809_81000000_04030201, 0,0,0,0,8'h00);
    // swaps, with a kept load (r5) and a dropped load (A)
    v(0,0,8'h00,G,                     1,0,0,0,0,8'h00, 128'h00000000_04030201_81000000_06070809, 0,0,0,0,8'h00);
    v(0,1,8'h05,dw(5,8'h55),           1,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 0,0,0,0,8'h00);
    v(0,1,8'h00,dw(0,8'hEE),           1,0,0,0,0,8'h00, 128'h00000000_04030201_81005500_06070809, 0,0,0,0,8'h00);
    v(0,0,8'h00,G,                     1,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 0,0,0,0,8'h00);
    // save with ready pattern 1,0,1,1,0,1; swap/start ignored while busy
    v(0,0,8'h00,G,                     0,1,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h01);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h02);
    v(0,0,8'h00,G,                     1,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h02);
    v(0,0,8'h00,G,                     0,0,1,1,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h03);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h04);
    v(0,0,8'h00,G,                     0,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,1,0,8'h04);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_06070809_81005500_04030201, 0,1,0,0,8'h00);
    v(0,0,8'h00,G,                     0,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 0,0,0,0,8'h00);
    // restore D,C,B,A; load to Y alongside D write applies, load to A alongside A write dropped
    v(0,0,8'h00,G,                     0,0,1,0,0,8'h00, 128'h00000000_06070809_81005500_04030201, 1,0,0,1,8'h00);
    v(0,1,8'h02,dw(2,8'h77),           0,0,0,0,1,8'h0D, 128'h00000000_06070809_81005500_0D770201, 1,0,0,1,8'h00);
    v(0,0,8'h00,G,                     0,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_0D770201, 1,0,0,1,8'h00);
    v(0,0,8'h00,G,                     0,0,0,0,1,8'h0C, 128'h00000000_06070809_81005500_0D0C0201, 1,0,0,1,8'h00);
    v(0,0,8'h00,G,                     0,0,0,0,1,8'h0B, 128'h00000000_06070809_81005500_0D0C0B01, 1,0,0,1,8'h00);
    v(0,1,8'h00,dw(0,8'hEE),           0,0,0,0,1,8'h0A, 128'h00000000_06070809_81005500_0D0C0B0A, 0,1,0,0,8'h00);
    v(0,0,8'h00,G,                     0,0,0,0,0,8'h00, 128'h00000000_06070809_81005500_0D0C0B0A, 0,0,0,0,8'h00);
    // reset after the 2nd save handshake, then a fresh save from idx 0
    v(0,0,8'h00,G,                     0,1,0,0,0,8'h00, 128'h00000000_06070809_81005500_0D0C0B0A, 1,0,1,0,8'h0A);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_06070809_81005500_0D0C0B0A, 1,0,1,0,8'h0B);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_06070809_81005500_0D0C0B0A, 1,0,1,0,8'h0C);
    v(1,1,8'h05,dw(5,8'h99),           0,0,0,1,1,8'h44, 128'h0,                                   0,0,0,0,8'h00);
    v(0,1,8'h01,dw(1,8'h42),           0,1,0,0,0,8'h00, 128'h00000000_00000000_00000000_00004200, 1,0,1,0,8'h00);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_00000000_00000000_00004200, 1,0,1,0,8'h42);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_00000000_00000000_00004200, 1,0,1,0,8'h00);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_00000000_00000000_00004200, 1,0,1,0,8'h00);
    v(0,0,8'h00,G,                     0,0,0,1,0,8'h00, 128'h00000000_00000000_00000000_00004200, 0,1,0,0,8'h00);

    foreach (vq[i]) begin
      rst = vq[i].rst; load_en = vq[i].en; load_addr = vq[i].addr; data_line = vq[i].dl;
      swap = vq[i].swap; save0 = vq[i].save; rest0 = vq[i].rest;
      if0.out_ready = vq[i].ordy; if0.in_valid = vq[i].ival; if0.in_data = vq[i].idat;
      tick();
      chk($sformatf("v%0d regs", i), 128'(reg_line0), vq[i].e_regs);
      chk($sformatf("v%0d busy", i), 128'(busy0), 128'(vq[i].e_busy));
      chk($sformatf("v%0d done", i), 128'(done0), 128'(vq[i].e_done));
      chk($sformatf("v%0d out_valid", i), 128'(if0.out_valid), 128'(vq[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 128'(if0.in_ready), 128'(vq[i].e_ir));
      chk($sformatf("v%0d out_data", i), 128'(if0.out_data), 128'(vq[i].e_od));
    end
    rst = 0; load_en = 0; swap = 0; save0 = 0; rest0 = 0;
    if0.out_ready = 0; if0.in_valid = 0;

    // CTX_COUNT=1: one handshake completes each stream
    load_en = 1; load_addr = 8'h00; data_line = dw(0, 8'h5C);
    tick();
    load_en = 0; save1 = 1;
    tick();
    save1 = 0;
    chk("c1 save busy", 128'(busy1), 128'(1'b1));
    chk("c1 out_valid", 128'(if1.out_valid), 128'(1'b1));
    chk("c1 out_data", 128'(if1.out_data), 128'(8'h5C));
    if1.out_ready = 1;
    tick();
    if1.out_ready = 0;
    chk("c1 save done", 128'(done1), 128'(1'b1));
    chk("c1 save idle", 128'(busy1), 128'(1'b0));
    tick();
    chk("c1 done pulse", 128'(done1), 128'(1'b0));
    rest1 = 1;
    tick();
    rest1 = 0;
    chk("c1 in_ready", 128'(if1.in_ready), 128'(1'b1));
    if1.in_valid = 1; if1.in_data = 8'hC3;
    tick();
    if1.in_valid = 0;
    chk("c1 rest done", 128'(done1), 128'(1'b1));
    chk("c1 rest busy", 128'(busy1), 128'(1'b0));
    chk("c1 A", 128'(reg_line1[0]), 128'(8'hC3));

    // randomized traffic against the model
    rst = 1;
    model_step();
    tick();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      load_en = ($urandom_range(0, 2) == 0);
      load_addr = 8'($urandom_range(0, 19));
      data_line = {$urandom, $urandom, $urandom, $urandom};
      swap = ($urandom_range(0, 4) == 0);
      save0 = ($urandom_range(0, 7) == 0);
      rest0 = ($urandom_range(0, 7) == 0);
      if0.out_ready = 1'($urandom_range(0, 1));
      if0.in_valid = 1'($urandom_range(0, 1));
      if0.in_data = 8'($urandom);
      model_step();
      tick();
      foreach (m_r[i]) er[i] = m_r[i];
      chk($sformatf("r%0d regs", c), 128'(reg_line0), 128'(er));
      chk($sformatf("r%0d busy", c), 128'(busy0), 128'(m_mode != 0));
      chk($sformatf("r%0d done", c), 128'(done0), 128'(m_done));
      chk($sformatf("r%0d out_valid", c), 128'(if0.out_valid), 128'(m_mode == 1));
      chk($sformatf("r%0d in_ready", c), 128'(if0.in_ready), 128'(m_mode == 2));
      chk($sformatf("r%0d out_data", c), 128'(if0.out_data),
          128'((m_mode == 1) ? m_r[save_ord[m_k]] : 8'h00));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
